psum_port_arbiter: RTL and testbench
====================================

PSUM_PORT_ARBITER -- requirements
Module: psum_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, psum scratchpad address width.
REQ-002 Parameter DATA_WIDTH, default 16, psum word width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive grants to one owner (used only when PSUM_ARB_BURST_EN is defined).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req0, we0, lock0  input  1 each  accumulate-path request, write flag, burst hold.
REQ-007 addr0 / wdata0  input  ADDR_WIDTH / DATA_WIDTH  accumulate-path address and write data.
REQ-008 req1, we1, lock1  input  1 each  drain-path request, write flag, burst hold.
REQ-009 addr1 / wdata1  input  ADDR_WIDTH / DATA_WIDTH  drain-path address and write data.
REQ-010 gnt0, gnt1  output  1 each  access issued to the scratchpad this cycle.
REQ-011 rvalid0, rvalid1  output  1 each  rdata holds the read result for that requester.
REQ-012 rdata  output  DATA_WIDTH  registered copy of mem_rdata.
REQ-013 mem_en, mem_we  output  1 each  scratchpad enable and write enable.
REQ-014 mem_addr / mem_wdata  output  ADDR_WIDTH / DATA_WIDTH  scratchpad address and write data.
REQ-015 mem_rdata  input  DATA_WIDTH  scratchpad read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-016 FSM states: IDLE, OWN0, OWN1; state is registered and next state is combinational.
REQ-017 Each cycle at most one of gnt0/gnt1 is high; gntN is combinational from current requests and state.
REQ-018 IDLE: if only one req is high, grant it; if both are high, grant the requester that is not last_owner; the FSM goes to OWNx of the granted requester, else stays in IDLE.
REQ-019 OWNx without burst: re-arbitrate every cycle exactly as in IDLE, so simultaneous requests alternate every cycle.
REQ-020 Memory outputs in a grant cycle: mem_en=1, mem_we=weN, mem_addr=addrN, mem_wdata=wdataN.
REQ-021 Memory outputs with no grant: mem_en=0, mem_we=0; address and data are don't-care.
REQ-022 last_owner register updates to the granted index on every grant.
REQ-023 Read latency: a read grant in cycle t gives rvalidN=1 and rdata=mem_rdata in cycle t+2; mem_rdata is sampled in t+1 and registered into rdata at the t+1→t+2 edge.
REQ-024 Write grants produce no rvalid.
REQ-025 A requester drops reqN when it samples gntN; a request held high is re-served.
REQ-026 Same-address read and write in consecutive cycles: no forwarding; the scratchpad's read-first/write-first behaviour is what is seen.
REQ-027 Grant-to-grant starvation bound for a requester with req held: 2 cycles without burst, MAX_BURST+1 cycles with burst.

Reset
REQ-028 reset_n low asynchronously forces: state=IDLE, last_owner=1 (requester 0 wins the first tie), burst count=0, rvalid0/1=0, rdata=0.
REQ-029 While reset_n is low, all grant and memory outputs are 0.
REQ-030 A read in flight when reset asserts is discarded; no rvalid is produced after release.

Configuration
REQ-031 Macro PSUM_ARB_BURST_EN defined: in OWNx with reqx=1 and lockx=1 and burst_cnt<MAX_BURST-1, grant x again and increment burst_cnt; otherwise clear burst_cnt and re-arbitrate.
REQ-032 PSUM_ARB_BURST_EN undefined: lock0/lock1 are ignored, no burst counter is built, and REQ-019 applies.

Structure
REQ-033 Shared package psum_pkg holds the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and requester index constants REQ_ACC=0, REQ_DRAIN=1.
REQ-034 Sub-module psum_rr_pick: a combinational 2-way round-robin picker with inputs req[1:0] and last_owner, and output gnt[1:0].

Verification
REQ-035 Only req0 read addr=5, mem holds 0x00AB -> gnt0 in cycle 0, rvalid0=1 and rdata=0x00AB in cycle 2.
REQ-036 req0 and req1 held for 6 cycles from reset -> grants are 0,1,0,1,0,1.
REQ-037 Burst enabled, MAX_BURST=4, req0+lock0 held, req1 held -> grants are 0,0,0,0,1,0,0,0,0,1.
REQ-038 req1 write addr=3 data=0x1234, then req0 read addr=3 -> mem_we=1 with addr 3 in cycle 0, then read returns 0x1234.
REQ-039 reset_n pulsed low one cycle after a read grant -> no rvalid, state IDLE, next tie granted to req0.
REQ-040 Burst disabled, lock0 held with req0 and req1 -> strict alternation; lock0 has no effect.

Source files
------------

// File: rtl/psum_port_arbiter_pkg.sv
// Shared definitions for the psum scratchpad port arbiter: FSM encoding and requester indices.
package psum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } psum_state_e;

  localparam logic REQ_ACC   = 1'b0;
  localparam logic REQ_DRAIN = 1'b1;

  function automatic psum_state_e own_state(input logic idx);
    return (idx == REQ_DRAIN) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/psum_port_arbiter_if.sv
// Bundle of the accumulate/drain requester ports and the scratchpad port seen by the arbiter.
interface psum_port_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  req0, we0, lock0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  req1, we1, lock1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/psum_port_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: a tie goes to the requester that did not own last.
module psum_rr_pick
  import psum_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_owner == REQ_ACC) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/psum_port_arbiter.sv
// Arbitrates the accumulate and drain paths onto one single-port psum scratchpad.
// Define PSUM_ARB_BURST_EN to let a locked owner keep the port for up to MAX_BURST grants.
module psum_port_arbiter
  import psum_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  psum_port_arbiter_if.slave bus
);

  psum_state_e           state_q, state_d;
  logic                  last_owner_q, last_owner_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_idx_q, rd_idx_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0]            pick_gnt;
  logic [1:0]            gnt;
  logic [1:0]            gnt_out;
  logic                  we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;

  psum_rr_pick u_pick (
    .req        ({bus.req1, bus.req0}),
    .last_owner (last_owner_q),
    .gnt        (pick_gnt)
  );

`ifdef PSUM_ARB_BURST_EN
  localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // A locked owner keeps the port; any arbitrated grant restarts the count.
  always_comb begin
    gnt         = pick_gnt;
    burst_cnt_d = '0;
    if (state_q == OWN0 && bus.req0 && bus.lock0 && burst_cnt_q < CNT_LIMIT) begin
      gnt         = 2'b01;
      burst_cnt_d = burst_cnt_q + 1'b1;
    end else if (state_q == OWN1 && bus.req1 && bus.lock1 && burst_cnt_q < CNT_LIMIT) begin
      gnt         = 2'b10;
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign gnt        = pick_gnt;
  assign unused_cfg = ^{bus.lock0, bus.lock1, state_q, MAX_BURST[0]};
`endif

  // Grants and the memory port are forced quiet while reset is held.
  assign gnt_out = gnt & {2{reset_n}};

  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (gnt_out[REQ_ACC]) begin
      we_sel    = bus.we0;
      addr_sel  = bus.addr0;
      wdata_sel = bus.wdata0;
    end else if (gnt_out[REQ_DRAIN]) begin
      we_sel    = bus.we1;
      addr_sel  = bus.addr1;
      wdata_sel = bus.wdata1;
    end
  end

  always_comb begin
    state_d      = IDLE;
    last_owner_d = last_owner_q;
    if (gnt[REQ_ACC]) begin
      state_d      = own_state(REQ_ACC);
      last_owner_d = REQ_ACC;
    end else if (gnt[REQ_DRAIN]) begin
      state_d      = own_state(REQ_DRAIN);
      last_owner_d = REQ_DRAIN;
    end
    // Read data arrives one cycle after the grant and is registered one cycle later.
    rd_pend_d = (|gnt) && !we_sel;
    rd_idx_d  = gnt[REQ_DRAIN];
    rvalid0_d = rd_pend_q && (rd_idx_q == REQ_ACC);
    rvalid1_d = rd_pend_q && (rd_idx_q == REQ_DRAIN);
    rdata_d   = rd_pend_q ? bus.mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= REQ_DRAIN;
      rd_pend_q    <= 1'b0;
      rd_idx_q     <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      rd_pend_q    <= rd_pend_d;
      rd_idx_q     <= rd_idx_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.gnt0      = gnt_out[REQ_ACC];
  assign bus.gnt1      = gnt_out[REQ_DRAIN];
  assign bus.mem_en    = |gnt_out;
  assign bus.mem_we    = we_sel;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_psum_port_arbiter.sv
// Directed and random stimulus for psum_port_arbiter against a grant/memory reference model.
module tb_psum_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk;
  logic reset_n;

  psum_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  psum_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scratchpad seen by the DUT: read-first, one-cycle read latency.
  logic [DW-1:0] tb_mem [64];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      tb_mem[pre_addr] <= pre_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= tb_mem[bus.mem_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [64];
  int            last_owner;
  int            prev_g;
  int            streak;
  bit            p0_v, p1_v;
  int            p0_i, p1_i;
  logic [DW-1:0] p0_d, p1_d;
  int            spec_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r0, input bit w0, input bit l0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input bit r1, input bit w1, input bit l1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1, input int sg);
    int            eg;
    int            og;
    bit            cont;
    bit            ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bus.req0 = r0; bus.we0 = w0; bus.lock0 = l0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.lock1 = l1; bus.addr1 = a1; bus.wdata1 = d1;
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_rvalid0", bus.rvalid0, 0);
      chk("rst_rvalid1", bus.rvalid1, 0);
      chk("rst_rdata", bus.rdata, 0);
      last_owner = 1; prev_g = -1; streak = 0; p0_v = 0; p1_v = 0;
    end else begin
      cont = 0;
      eg   = -1;
`ifdef PSUM_ARB_BURST_EN
      if (prev_g == 0 && r0 && l0 && streak < MB) begin
        eg = 0; cont = 1;
      end else if (prev_g == 1 && r1 && l1 && streak < MB) begin
        eg = 1; cont = 1;
      end
`endif
      if (eg < 0) begin
        if (r0 && r1)  eg = (last_owner == 0) ? 1 : 0;
        else if (r0)   eg = 0;
        else if (r1)   eg = 1;
      end
      og = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : -1);
      ew = (eg == 0) ? w0 : ((eg == 1) ? w1 : 1'b0);
      ea = (eg == 1) ? a1 : a0;
      ed = (eg == 1) ? d1 : d0;
      chk("gnt0", bus.gnt0, eg == 0);
      chk("gnt1", bus.gnt1, eg == 1);
      chk("mem_en", bus.mem_en, eg >= 0);
      chk("mem_we", bus.mem_we, ew);
      if (eg >= 0) begin
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_wdata", bus.mem_wdata, ed);
      end
      chk("rvalid0", bus.rvalid0, p1_v && p1_i == 0);
      chk("rvalid1", bus.rvalid1, p1_v && p1_i == 1);
      if (p1_v) chk("rdata", bus.rdata, p1_d);
      if (sg != -2) chk("spec_gnt", og, sg);
      if (spec_rd >= 0) begin
        chk("spec_rvalid0", bus.rvalid0, 1);
        chk("spec_rdata", bus.rdata, spec_rd);
      end
      p1_v = p0_v; p1_i = p0_i; p1_d = p0_d;
      p0_v = (eg >= 0) && !ew;
      p0_i = eg;
      p0_d = ref_mem[ea];
      if (eg >= 0 && ew) ref_mem[ea] = ed;
      if (eg >= 0) begin
        streak     = cont ? streak + 1 : 1;
        last_owner = eg;
      end else begin
        streak = 0;
      end
      prev_g = eg;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int sg);
    step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, sg);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(-2);
    reset_n = 1'b1;
  endtask

  initial begin
    int pat[10];
    reset_n  = 1'b0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    spec_rd  = -1;
    last_owner = 1; prev_g = -1; streak = 0;
    p0_v = 0; p1_v = 0; p0_i = 0; p1_i = 0; p0_d = '0; p1_d = '0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    @(posedge clk);
    #1;
    for (int a = 0; a < 64; a++) begin
      pre_we   = 1'b1;
      pre_addr = AW'(a);
      pre_data = (a == 5) ? 16'h00AB : DW'($urandom);
      ref_mem[a] = pre_data;
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;

    // Requests during reset must not be granted.
    step(1, 0, 0, 6'd5, '0, 1, 0, 0, 6'd9, '0, -2);
    reset_n = 1'b1;

    // Single read of address 5 returns 0x00AB two cycles later.
    step(1, 0, 0, 6'd5, '0, 0, 0, 0, '0, '0, 0);
    idle(-1);
    spec_rd = 16'h00AB;
    idle(-1);
    spec_rd = -1;

    // Both held from reset alternate 0,1,0,1,0,1.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1, 0, 0, AW'($urandom), '0, 1, 0, 0, AW'($urandom), '0, i % 2);

    // req0 with lock0 against req1.
    do_reset();
`ifdef PSUM_ARB_BURST_EN
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
    pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    for (int i = 0; i < 10; i++)
      step(1, 0, 1, AW'($urandom), '0, 1, 0, 0, AW'($urandom), '0, pat[i]);

    // Drain write to address 3, then accumulate read sees it.
    idle(-1);
    idle(-1);
    step(0, 0, 0, '0, '0, 1, 1, 0, 6'd3, 16'h1234, 1);
    step(1, 0, 0, 6'd3, '0, 0, 0, 0, '0, '0, 0);
    idle(-1);
    spec_rd = 16'h1234;
    idle(-1);
    spec_rd = -1;

    // Reset one cycle after a read grant discards the read.
    step(1, 0, 0, 6'd7, '0, 0, 0, 0, '0, '0, 0);
    reset_n = 1'b0;
    idle(-2);
    reset_n = 1'b1;
    idle(-1);
    idle(-1);
    step(1, 0, 0, 6'd1, '0, 1, 0, 0, 6'd2, '0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), -2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
